alu_pipe_unit: RTL and testbench
================================

# alu_pipe_unit

Parametrised, pipelined integer execution unit for the Tomasulo back end. Accepts one issued operation per cycle from the ALU reservation station, computes the result and branch/jump flags over a configurable number of pipeline stages, and holds finished results in an output queue until the common-data-bus (CDB) arbiter grants it. Credit-based issue flow control guarantees the queue never overflows and the pipeline never stalls.

## Interface
Parameters:
- XLEN, 32: operand/result width; power of two, at least 8.
- TAG_W, 6: ROB/RS tag width.
- STAGES, 2: issue-to-visible latency in cycles; 1..4.
- OUT_DEPTH, 2: output queue entries and in-flight credit limit; 1..8.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  operation presented.
- issue_ready  out  1  unit can accept; transfer occurs when issue_valid and issue_ready are both high.
- op1, op2  in  XLEN  operands.
- alu_ext  in  3  operation class.
- funct3  in  3  RISC-V funct3.
- tag_in  in  TAG_W  destination tag.
- flush  in  1  kill all in-flight and queued results.
- cdb_req  out  1  queue head valid.
- cdb_grant  in  1  arbiter accepts head this cycle.
- res  out  XLEN  head result.
- tag_out  out  TAG_W  head tag.
- branch, branch_taken, jalr, store_pc  out  1 each  head control flags.

## Operation
- alu_ext classes:
  - 0: R/I ALU, op from funct3.
  - 1: JAL, ADD, store_pc=1.
  - 2: JALR, ADD, jalr=1, store_pc=1.
  - 3: branch, SUB compare, branch=1.
  - 4: alternate R-type; funct3 0 gives SUB, funct3 5 gives SRA.
  - 5: ADD (address/LUI/AUIPC).
  - 6, 7: ADD with all flags 0.
- funct3 decode for classes 0 and 4: 0 ADD/SUB, 1 SLL, 2 SLT (signed), 3 SLTU (unsigned), 4 XOR, 5 SRL/SRA, 6 OR, 7 AND.
- Shift amount: op2[$clog2(XLEN)-1:0]. SLT/SLTU result is zero-extended 0/1. All arithmetic is modulo 2^XLEN.
- Branch condition (class 3): funct3 0 EQ, 1 NE, 4 LT, 5 GE, 6 LTU, 7 GEU; 2 and 3 give branch_taken=0. res = op1-op2 for branches. Flags other than those listed are 0.
- Credit counter inflight (0..OUT_DEPTH) counts accepted but not yet granted operations:
  - Increments on issue.
  - Decrements on a grant while cdb_req is high.
  - Both in the same cycle leave it unchanged.
- issue_ready = !rst && inflight < OUT_DEPTH. It does not depend combinationally on cdb_grant: a grant frees a credit only from the next cycle.
- Queue is FIFO ordered; results leave in issue order. There is no bypass around the queue.
- cdb_grant while cdb_req is low is ignored.
- flush: on that edge all stage valids, queue occupancy and inflight are cleared. A same-cycle issue is discarded and a same-cycle grant is ignored. cdb_req is low the next cycle.
- Reset: all registers cleared. cdb_req=0, res=0, tag_out=0, all flags 0, inflight=0, issue_ready=0 during reset and 1 the cycle after.

## Timing
- Issue in cycle c gives a result visible at the queue head in cycle c+STAGES, if all earlier results have drained.
- STAGES=1: compute is combinational into the queue write.
- STAGES>1: compute is registered at stage 1; STAGES-2 delay stages follow, then the queue write.
- Sustained one result per cycle requires OUT_DEPTH >= STAGES+1 with grant always high. A smaller OUT_DEPTH throttles issue deterministically; this is not an error.
- Head outputs are registered from queue storage, with no combinational path from issue inputs.
- Queue full and empty follow from inflight. A simultaneous write and pop at full is impossible by construction; at empty, a write and pop in the same cycle never occurs because there is no bypass.

## Configuration
- Macro ALU_PIPE_FLUSH_EN.
  - Defined: flush behaves as above.
  - Undefined: flush port remains for a stable interface but is ignored, and the flush logic is not synthesised.

## Structure
- Package alu_pkg: alu_op_e enum (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU), alu_ext class constants, branch funct3 constants, and a packed alu_result_t struct {res, tag, branch, branch_taken, jalr, store_pc}, parameterised through localparam widths.
- Sub-module alu_out_fifo: synchronous FIFO of alu_result_t, depth OUT_DEPTH, with push/pop/flush and registered head.
- Decode, compute and delay stages are inline.

## Test plan
- STAGES=2, OUT_DEPTH=3, grant tied high; issue ADD 5+7 tag 3 in cycle 0 -> cdb_req=1, res=12, tag_out=3 in cycle 2 only.
- Class 4 funct3 5, op1=0x80000000, op2=4 -> res=0xF8000000; class 0 same -> 0x08000000. SLTU 1 vs 0xFFFFFFFF -> 1; SLT -> 0.
- Class 3 BLTU op1=1, op2=0xFFFFFFFF -> branch=1, branch_taken=1; BLT -> branch_taken=0; JALR -> jalr=1, store_pc=1, res=op1+op2.
- OUT_DEPTH=2, grant low, continuous issue -> exactly 2 accepted, issue_ready=0. One grant -> issue_ready=1 the following cycle; results popped in tag order.
- Flush with 2 queued and 1 in flight plus same-cycle issue (ALU_PIPE_FLUSH_EN) -> cdb_req=0 next cycle, no stale tag ever appears, inflight=0.
- rst asserted mid-stream for one cycle -> all outputs 0, issue_ready=0 during rst and 1 after; first post-reset issue returns correct result after STAGES cycles.

Source files
------------

// File: rtl/alu_pipe_unit_pkg.sv
// alu_pkg: shared opcode enum, alu_ext class codes, branch funct3 codes and result record for alu_pipe_unit
package alu_pkg;
  localparam int ALU_XLEN = 32;
  localparam int ALU_TAG_W = 6;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_e;
  localparam logic [2:0] EXT_ALU = 3'd0, EXT_JAL = 3'd1, EXT_JALR = 3'd2, EXT_BR = 3'd3,
                         EXT_ALT = 3'd4, EXT_ADDR = 3'd5;
  localparam logic [2:0] BR_EQ = 3'd0, BR_NE = 3'd1, BR_LT = 3'd4, BR_GE = 3'd5,
                         BR_LTU = 3'd6, BR_GEU = 3'd7;
  typedef struct packed {
    logic [ALU_XLEN-1:0]  res;
    logic [ALU_TAG_W-1:0] tag;
    logic                 branch;
    logic                 branch_taken;
    logic                 jalr;
    logic                 store_pc;
  } alu_result_t;
endpackage

// File: rtl/alu_pipe_unit_if.sv
// alu_pipe_unit_if: issue port (valid/ready, operands, class, funct3, tag, flush) and CDB port (req/grant, result, tag, flags)
interface alu_pipe_unit_if #(parameter int XLEN = 32, parameter int TAG_W = 6);
  logic             issue_valid, issue_ready, flush, cdb_req, cdb_grant;
  logic             branch, branch_taken, jalr, store_pc;
  logic [XLEN-1:0]  op1, op2, res;
  logic [2:0]       alu_ext, funct3;
  logic [TAG_W-1:0] tag_in, tag_out;
  modport master (
    output issue_valid, op1, op2, alu_ext, funct3, tag_in, flush, cdb_grant,
    input  issue_ready, cdb_req, res, tag_out, branch, branch_taken, jalr, store_pc
  );
  modport slave (
    input  issue_valid, op1, op2, alu_ext, funct3, tag_in, flush, cdb_grant,
    output issue_ready, cdb_req, res, tag_out, branch, branch_taken, jalr, store_pc
  );
endinterface

// File: rtl/alu_pipe_unit_fifo.sv
// alu_out_fifo: in-order result queue; ports clk, rst, i_push, i_pop, i_flush, i_data -> o_valid, o_head
// Entry 0 is always the head, so o_head comes straight from a flop; pops shift down and zero the vacated top.
module alu_out_fifo import alu_pkg::*; #(
  parameter int  DEPTH = 2,
  parameter type T     = alu_result_t
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic i_pop,
  input  logic i_flush,
  input  T     i_data,
  output logic o_valid,
  output T     o_head
);
  localparam int CW = $clog2(DEPTH + 1);
  T r_q [DEPTH];
  T w_nxt [DEPTH];
  logic [CW-1:0] r_cnt, w_wi;
  assign w_wi = r_cnt - CW'(i_pop);
  assign o_valid = r_cnt != '0;
  assign o_head = r_q[0];
  always_comb begin
    w_nxt = r_q;
    if (i_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) w_nxt[i] = r_q[i + 1];
      w_nxt[DEPTH - 1] = '0;
    end
    for (int i = 0; i < DEPTH; i++) if (i_push && CW'(i) == w_wi) w_nxt[i] = i_data;
  end
  always_ff @(posedge clk)
    if (rst || i_flush) begin
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
      r_q <= w_nxt;
    end
endmodule

// File: rtl/alu_pipe_unit.sv
// alu_pipe_unit: pipelined integer ALU with credit-limited output queue feeding the CDB; ports clk, rst, bus (alu_pipe_unit_if.slave)
// Optional macro ALU_PIPE_FLUSH_EN enables flush; otherwise bus.flush is ignored.
module alu_pipe_unit import alu_pkg::*; #(
  parameter int XLEN = ALU_XLEN,
  parameter int TAG_W = ALU_TAG_W,
  parameter int STAGES = 2,
  parameter int OUT_DEPTH = 2
) (
  input logic clk,
  input logic rst,
  alu_pipe_unit_if.slave bus
);
  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(OUT_DEPTH + 1);
  typedef struct packed {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
    logic             branch;
    logic             branch_taken;
    logic             jalr;
    logic             store_pc;
  } res_t;
  logic w_flush, w_issue, w_pop, w_push, w_head_v, w_lt, w_ltu, w_eq, w_cond;
  logic [CW-1:0] r_inf;
  logic [SW-1:0] w_sh;
  alu_op_e w_op;
  res_t w_comp, w_din, w_head;
`ifdef ALU_PIPE_FLUSH_EN
  assign w_flush = bus.flush;
`else
  logic w_unused_flush;
  assign w_unused_flush = bus.flush;
  assign w_flush = 1'b0;
`endif
  // Credits cover pipeline plus queue, so the queue can never overflow.
  assign bus.issue_ready = !rst && r_inf < CW'(OUT_DEPTH);
  assign w_issue = bus.issue_valid && bus.issue_ready && !w_flush;
  assign w_pop = bus.cdb_grant && w_head_v;
  assign w_sh = bus.op2[SW-1:0];
  assign w_lt = $signed(bus.op1) < $signed(bus.op2);
  assign w_ltu = bus.op1 < bus.op2;
  assign w_eq = bus.op1 == bus.op2;
  always_comb begin
    w_op = ALU_ADD;
    if (bus.alu_ext == EXT_BR) w_op = ALU_SUB;
    else if (bus.alu_ext == EXT_ALU || bus.alu_ext == EXT_ALT)
      case (bus.funct3)
        3'd0: w_op = bus.alu_ext == EXT_ALT ? ALU_SUB : ALU_ADD;
        3'd1: w_op = ALU_SLL;
        3'd2: w_op = ALU_SLT;
        3'd3: w_op = ALU_SLTU;
        3'd4: w_op = ALU_XOR;
        3'd5: w_op = bus.alu_ext == EXT_ALT ? ALU_SRA : ALU_SRL;
        3'd6: w_op = ALU_OR;
        default: w_op = ALU_AND;
      endcase
  end
  always_comb
    case (bus.funct3)
      BR_EQ:   w_cond = w_eq;
      BR_NE:   w_cond = !w_eq;
      BR_LT:   w_cond = w_lt;
      BR_GE:   w_cond = !w_lt;
      BR_LTU:  w_cond = w_ltu;
      BR_GEU:  w_cond = !w_ltu;
      default: w_cond = 1'b0;
    endcase
  always_comb begin
    w_comp = '0;
    case (w_op)
      ALU_SUB:  w_comp.res = bus.op1 - bus.op2;
      ALU_AND:  w_comp.res = bus.op1 & bus.op2;
      ALU_OR:   w_comp.res = bus.op1 | bus.op2;
      ALU_XOR:  w_comp.res = bus.op1 ^ bus.op2;
      ALU_SLL:  w_comp.res = bus.op1 << w_sh;
      ALU_SRL:  w_comp.res = bus.op1 >> w_sh;
      ALU_SRA:  w_comp.res = $unsigned($signed(bus.op1) >>> w_sh);
      ALU_SLT:  w_comp.res = XLEN'(w_lt);
      ALU_SLTU: w_comp.res = XLEN'(w_ltu);
      default:  w_comp.res = bus.op1 + bus.op2;
    endcase
    w_comp.tag = bus.tag_in;
    w_comp.branch = bus.alu_ext == EXT_BR;
    w_comp.branch_taken = w_comp.branch && w_cond;
    w_comp.jalr = bus.alu_ext == EXT_JALR;
    w_comp.store_pc = bus.alu_ext == EXT_JAL || bus.alu_ext == EXT_JALR;
  end
  if (STAGES == 1) begin : g_comb
    assign w_push = w_issue;
    assign w_din = w_comp;
  end else begin : g_pipe
    // Stage 0 registers the computed result; later entries are pure delay.
    res_t r_d [STAGES-1];
    logic r_v [STAGES-1];
    always_ff @(posedge clk)
      if (rst) begin
        for (int i = 0; i < STAGES - 1; i++) begin
          r_v[i] <= 1'b0;
          r_d[i] <= '0;
        end
      end else begin
        r_v[0] <= w_issue;
        r_d[0] <= w_comp;
        for (int i = 1; i < STAGES - 1; i++) begin
          r_v[i] <= r_v[i-1] && !w_flush;
          r_d[i] <= r_d[i-1];
        end
      end
    assign w_push = r_v[STAGES-2];
    assign w_din = r_d[STAGES-2];
  end
  alu_out_fifo #(.DEPTH(OUT_DEPTH), .T(res_t)) u_fifo (
    .clk(clk), .rst(rst), .i_push(w_push), .i_pop(w_pop), .i_flush(w_flush),
    .i_data(w_din), .o_valid(w_head_v), .o_head(w_head)
  );
  always_ff @(posedge clk)
    if (rst || w_flush) r_inf <= '0;
    else r_inf <= r_inf + CW'(w_issue) - CW'(w_pop);
  assign bus.cdb_req = w_head_v;
  assign bus.res = w_head.res;
  assign bus.tag_out = w_head.tag;
  assign bus.branch = w_head.branch;
  assign bus.branch_taken = w_head.branch_taken;
  assign bus.jalr = w_head.jalr;
  assign bus.store_pc = w_head.store_pc;
endmodule

// File: tb/tb_alu_pipe_unit.sv
// tb_alu_pipe_unit: directed self-checking bench; unit A (STAGES=2, OUT_DEPTH=4), unit B (STAGES=3, OUT_DEPTH=2)
module tb_alu_pipe_unit;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0]  ext;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  fl;
  } vec_t;
  alu_pipe_unit_if #(.XLEN(32), .TAG_W(6)) ia ();
  alu_pipe_unit_if #(.XLEN(32), .TAG_W(6)) ib ();
  alu_pipe_unit #(.XLEN(32), .TAG_W(6), .STAGES(2), .OUT_DEPTH(4)) u_a (.clk(clk), .rst(rst), .bus(ia));
  alu_pipe_unit #(.XLEN(32), .TAG_W(6), .STAGES(3), .OUT_DEPTH(2)) u_b (.clk(clk), .rst(rst), .bus(ib));
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic drive_a(input logic v, input logic [2:0] ext, f3, input logic [31:0] a, b, input logic [5:0] t);
    ia.issue_valid = v;
    ia.alu_ext = ext;
    ia.funct3 = f3;
    ia.op1 = a;
    ia.op2 = b;
    ia.tag_in = t;
  endtask
  task automatic drive_b(input logic v, input logic [2:0] ext, f3, input logic [31:0] a, b, input logic [5:0] t);
    ib.issue_valid = v;
    ib.alu_ext = ext;
    ib.funct3 = f3;
    ib.op1 = a;
    ib.op2 = b;
    ib.tag_in = t;
  endtask
  task automatic idle;
    drive_a(1'b0, 3'd0, 3'd0, 32'd0, 32'd0, 6'd0);
    drive_b(1'b0, 3'd0, 3'd0, 32'd0, 32'd0, 6'd0);
    ia.flush = 1'b0;
    ib.flush = 1'b0;
    ia.cdb_grant = 1'b1;
    ib.cdb_grant = 1'b0;
  endtask
  task automatic exec_a(input vec_t v, input logic [5:0] t, output logic req, output logic [31:0] r,
                        output logic [5:0] tg, output logic [3:0] fl);
    drive_a(1'b1, v.ext, v.f3, v.a, v.b, t);
    tick();
    ia.issue_valid = 1'b0;
    tick();
    req = ia.cdb_req;
    r = ia.res;
    tg = ia.tag_out;
    fl = {ia.branch, ia.branch_taken, ia.jalr, ia.store_pc};
  endtask
  task automatic test_reset;
    rst = 1'b1;
    idle();
    tick();
    tick();
    checks++;
    if ({ia.issue_ready, ib.issue_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready: got %b want 00", {ia.issue_ready, ib.issue_ready});
    end
    checks++;
    if ({ia.cdb_req, ia.res, ia.tag_out, ia.branch, ia.branch_taken, ia.jalr, ia.store_pc} !== 43'd0) begin
      errors++;
      $display("FAIL reset_outputs_a: got req=%b res=%h tag=%0d want all zero", ia.cdb_req, ia.res, ia.tag_out);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({ia.issue_ready, ib.issue_ready} !== 2'b11) begin
      errors++;
      $display("FAIL post_reset_ready: got %b want 11", {ia.issue_ready, ib.issue_ready});
    end
  endtask
  task automatic test_add_latency;
    drive_a(1'b1, EXT_ALU, 3'd0, 32'd5, 32'd7, 6'd3);
    tick();
    ia.issue_valid = 1'b0;
    checks++;
    if (ia.cdb_req !== 1'b0) begin
      errors++;
      $display("FAIL add_cycle1_req: got %b want 0", ia.cdb_req);
    end
    tick();
    checks++;
    if ({ia.cdb_req, ia.res, ia.tag_out} !== {1'b1, 32'd12, 6'd3}) begin
      errors++;
      $display("FAIL add_cycle2: got req=%b res=%0d tag=%0d want req=1 res=12 tag=3", ia.cdb_req, ia.res, ia.tag_out);
    end
    tick();
    checks++;
    if (ia.cdb_req !== 1'b0) begin
      errors++;
      $display("FAIL add_cycle3_req: got %b want 0", ia.cdb_req);
    end
  endtask
  task automatic test_alu_ops;
    vec_t tv [13] = '{
      '{EXT_ALT,  3'd5, 32'h8000_0000, 32'd4,         32'hF800_0000, 4'b0000},
      '{EXT_ALU,  3'd5, 32'h8000_0000, 32'd4,         32'h0800_0000, 4'b0000},
      '{EXT_ALU,  3'd3, 32'd1,         32'hFFFF_FFFF, 32'd1,         4'b0000},
      '{EXT_ALU,  3'd2, 32'd1,         32'hFFFF_FFFF, 32'd0,         4'b0000},
      '{EXT_ALU,  3'd2, 32'hFFFF_FFFF, 32'd1,         32'd1,         4'b0000},
      '{EXT_ALT,  3'd0, 32'd3,         32'd5,         32'hFFFF_FFFE, 4'b0000},
      '{EXT_ALU,  3'd1, 32'd1,         32'd35,        32'd8,         4'b0000},
      '{EXT_ALU,  3'd4, 32'hF0F0,      32'hFF00,      32'h0FF0,      4'b0000},
      '{EXT_ALU,  3'd6, 32'hF0F0,      32'hFF00,      32'hFFF0,      4'b0000},
      '{EXT_ALU,  3'd7, 32'hF0F0,      32'hFF00,      32'hF000,      4'b0000},
      '{EXT_ALT,  3'd7, 32'hF0F0,      32'hFF00,      32'hF000,      4'b0000},
      '{EXT_ALU,  3'd0, 32'hFFFF_FFFF, 32'd1,         32'd0,         4'b0000},
      '{EXT_ADDR, 3'd3, 32'd10,        32'd20,        32'd30,        4'b0000}
    };
    logic req;
    logic [31:0] r;
    logic [5:0] tg;
    logic [3:0] fl;
    foreach (tv[i]) begin
      exec_a(tv[i], 6'(i + 1), req, r, tg, fl);
      checks++;
      if ({req, r, tg, fl} !== {1'b1, tv[i].r, 6'(i + 1), tv[i].fl}) begin
        errors++;
        $display("FAIL alu_op[%0d]: got req=%b res=%h tag=%0d flags=%b want req=1 res=%h tag=%0d flags=%b",
                 i, req, r, tg, fl, tv[i].r, i + 1, tv[i].fl);
      end
    end
  endtask
  task automatic test_branch;
    vec_t tv [11] = '{
      '{EXT_BR,   3'd6, 32'd1,         32'hFFFF_FFFF, 32'd2,         4'b1100},
      '{EXT_BR,   3'd4, 32'd1,         32'hFFFF_FFFF, 32'd2,         4'b1000},
      '{EXT_BR,   3'd0, 32'd7,         32'd7,         32'd0,         4'b1100},
      '{EXT_BR,   3'd1, 32'd7,         32'd7,         32'd0,         4'b1000},
      '{EXT_BR,   3'd5, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFE, 4'b1000},
      '{EXT_BR,   3'd7, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFE, 4'b1100},
      '{EXT_BR,   3'd2, 32'd7,         32'd7,         32'd0,         4'b1000},
      '{EXT_JALR, 3'd0, 32'h100,       32'd4,         32'h104,       4'b0011},
      '{EXT_JAL,  3'd0, 32'h200,       32'd8,         32'h208,       4'b0001},
      '{3'd6,     3'd0, 32'd3,         32'd4,         32'd7,         4'b0000},
      '{3'd7,     3'd1, 32'd3,         32'd4,         32'd7,         4'b0000}
    };
    logic req;
    logic [31:0] r;
    logic [5:0] tg;
    logic [3:0] fl;
    foreach (tv[i]) begin
      exec_a(tv[i], 6'(i + 40), req, r, tg, fl);
      checks++;
      if ({req, r, tg, fl} !== {1'b1, tv[i].r, 6'(i + 40), tv[i].fl}) begin
        errors++;
        $display("FAIL branch_op[%0d]: got req=%b res=%h tag=%0d flags=%b want req=1 res=%h tag=%0d flags=%b",
                 i, req, r, tg, fl, tv[i].r, i + 40, tv[i].fl);
      end
    end
  endtask
  task automatic test_credit;
    int acc = 0;
    ib.cdb_grant = 1'b0;
    for (int c = 0; c < 8; c++) begin
      drive_b(1'b1, EXT_ALU, 3'd0, 32'(10 + acc), 32'd0, 6'(10 + acc));
      if (ib.issue_ready) acc++;
      tick();
    end
    ib.issue_valid = 1'b0;
    checks++;
    if (acc !== 2) begin
      errors++;
      $display("FAIL credit_accepted: got %0d want 2", acc);
    end
    checks++;
    if ({ib.issue_ready, ib.cdb_req, ib.res, ib.tag_out} !== {1'b0, 1'b1, 32'd10, 6'd10}) begin
      errors++;
      $display("FAIL credit_full: got ready=%b req=%b res=%0d tag=%0d want ready=0 req=1 res=10 tag=10",
               ib.issue_ready, ib.cdb_req, ib.res, ib.tag_out);
    end
    ib.cdb_grant = 1'b1;
    #1;
    checks++;
    if (ib.issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL credit_grant_comb: got ready=%b want 0", ib.issue_ready);
    end
    tick();
    ib.cdb_grant = 1'b0;
    checks++;
    if ({ib.issue_ready, ib.cdb_req, ib.tag_out} !== {1'b1, 1'b1, 6'd11}) begin
      errors++;
      $display("FAIL credit_after_grant: got ready=%b req=%b tag=%0d want ready=1 req=1 tag=11",
               ib.issue_ready, ib.cdb_req, ib.tag_out);
    end
    ib.cdb_grant = 1'b1;
    tick();
    ib.cdb_grant = 1'b0;
    checks++;
    if ({ib.issue_ready, ib.cdb_req} !== 2'b10) begin
      errors++;
      $display("FAIL credit_drained: got ready=%b req=%b want ready=1 req=0", ib.issue_ready, ib.cdb_req);
    end
  endtask
  task automatic test_mid_reset;
    ib.cdb_grant = 1'b0;
    drive_b(1'b1, EXT_ALU, 3'd0, 32'd20, 32'd0, 6'd20);
    tick();
    drive_b(1'b1, EXT_ALU, 3'd0, 32'd21, 32'd0, 6'd21);
    tick();
    ib.issue_valid = 1'b0;
    tick();
    tick();
    checks++;
    if ({ib.cdb_req, ib.tag_out} !== {1'b1, 6'd20}) begin
      errors++;
      $display("FAIL mid_reset_pre: got req=%b tag=%0d want req=1 tag=20", ib.cdb_req, ib.tag_out);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({ib.issue_ready, ib.cdb_req, ib.res, ib.tag_out, ib.branch, ib.branch_taken, ib.jalr, ib.store_pc} !== 44'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got ready=%b req=%b res=%h tag=%0d want all zero",
               ib.issue_ready, ib.cdb_req, ib.res, ib.tag_out);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({ib.issue_ready, ib.cdb_req} !== 2'b10) begin
      errors++;
      $display("FAIL mid_reset_after: got ready=%b req=%b want ready=1 req=0", ib.issue_ready, ib.cdb_req);
    end
    drive_b(1'b1, EXT_ALU, 3'd0, 32'd100, 32'd23, 6'd5);
    tick();
    ib.issue_valid = 1'b0;
    tick();
    checks++;
    if (ib.cdb_req !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_stale: got req=%b tag=%0d want req=0", ib.cdb_req, ib.tag_out);
    end
    tick();
    checks++;
    if ({ib.cdb_req, ib.res, ib.tag_out} !== {1'b1, 32'd123, 6'd5}) begin
      errors++;
      $display("FAIL mid_reset_result: got req=%b res=%0d tag=%0d want req=1 res=123 tag=5",
               ib.cdb_req, ib.res, ib.tag_out);
    end
    ib.cdb_grant = 1'b1;
    tick();
    ib.cdb_grant = 1'b0;
  endtask
  task automatic test_flush;
    int n = 0;
    ia.cdb_grant = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive_a(1'b1, EXT_ALU, 3'd0, 32'(k), 32'd0, 6'(k));
      ia.flush = k == 4;
      tick();
    end
    ia.issue_valid = 1'b0;
    ia.flush = 1'b0;
`ifdef ALU_PIPE_FLUSH_EN
    checks++;
    if ({ia.cdb_req, ia.issue_ready} !== 2'b01) begin
      errors++;
      $display("FAIL flush_next: got req=%b ready=%b want req=0 ready=1", ia.cdb_req, ia.issue_ready);
    end
    for (int c = 0; c < 6; c++) begin
      if (ia.cdb_req) n++;
      tick();
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL flush_stale: got %0d cycles with req want 0", n);
    end
    n = 0;
    for (int c = 0; c < 6; c++) begin
      drive_a(1'b1, EXT_ALU, 3'd0, 32'(30 + n), 32'd0, 6'(30 + n));
      if (ia.issue_ready) n++;
      tick();
    end
    ia.issue_valid = 1'b0;
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL flush_credits: got %0d accepted want 4", n);
    end
    n = 0;
    ia.cdb_grant = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (ia.cdb_req) begin
        checks++;
        if (ia.tag_out !== 6'(30 + n)) begin
          errors++;
          $display("FAIL flush_order[%0d]: got tag=%0d want %0d", n, ia.tag_out, 30 + n);
        end
        n++;
      end
      tick();
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL flush_drain_count: got %0d results want 4", n);
    end
`else
    checks++;
    if ({ia.cdb_req, ia.issue_ready, ia.tag_out} !== {1'b1, 1'b0, 6'd1}) begin
      errors++;
      $display("FAIL noflush_head: got req=%b ready=%b tag=%0d want req=1 ready=0 tag=1",
               ia.cdb_req, ia.issue_ready, ia.tag_out);
    end
    ia.cdb_grant = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      tick();
      checks++;
      if ({ia.cdb_req, ia.res, ia.tag_out} !== {1'b1, 32'(k), 6'(k)}) begin
        errors++;
        $display("FAIL noflush_order[%0d]: got req=%b res=%0d tag=%0d want req=1 res=%0d tag=%0d",
                 k, ia.cdb_req, ia.res, ia.tag_out, k, k);
      end
    end
    tick();
    checks++;
    if (ia.cdb_req !== 1'b0) begin
      errors++;
      $display("FAIL noflush_drained: got req=%b want 0", ia.cdb_req);
    end
`endif
    idle();
  endtask
  initial begin
    test_reset();
    test_add_latency();
    test_alu_ops();
    test_branch();
    test_credit();
    test_mid_reset();
    test_flush();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end, checks=%0d", checks);
    $fatal(1);
  end
endmodule
